// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmitter.
// Serializer state encoding plus the default bit period (100 MHz / 115200) and buffer depth.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int FIFO_DEPTH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the serializer: pushes are dropped when full, pops when empty.
// Zero-latency head read; full/empty/count come straight from registered occupancy.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic [7:0]                    i_dat,
  input  logic                          i_pop,
  output logic [7:0]                    o_dat,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dat   = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointers are exactly log2(depth) wide, so wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO; txd falls one edge after a byte lands in an idle, empty buffer.
// uart_tx_ready is low only while the FIFO is full; writes seen while it is low are ignored.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_ready,
  output logic       uart_txd,
  output logic       tx_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      r_state;
  tx_state_t      w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]     r_bit_idx;
  logic [2:0]     w_bit_nxt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nxt;
  logic           r_txd;
  logic           w_txd_nxt;
  logic           w_pop;
  logic           w_baud_last;

  logic [7:0]     w_fifo_dat;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [CW-1:0]  w_fifo_count;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (uart_tx_en),
    .i_dat   (uart_tx_data),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_dat),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign uart_tx_ready = ~w_fifo_full;
  assign uart_txd      = r_txd;
  assign tx_busy       = (r_state != IDLE) || (w_fifo_count != '0);
  assign w_baud_last   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  // r_txd holds the level for the current bit; w_txd_nxt is computed one edge ahead of each boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;

    case (r_state)
      IDLE: begin
        w_txd_nxt  = 1'b1;
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dat;
          w_txd_nxt   = 1'b0;
          w_state_nxt = START;
        end
      end

      START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_txd_nxt   = r_shift[0];
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      DATA: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt   = r_bit_idx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_txd_nxt   = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          w_bit_nxt  = '0;
          // Chain straight into the next start bit so queued bytes go out with no idle gap.
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dat;
            w_txd_nxt   = 1'b0;
            w_state_nxt = START;
          end else begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_W'(1);
        end
      end

      default: begin
        w_txd_nxt   = 1'b1;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4; expected line levels are built from the byte values.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_ready;
  logic       uart_txd;
  logic       tx_busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] exp_q [0:7];

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_txd      (uart_txd),
    .tx_busy       (tx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level at cycle cyc (0..FRAME-1) of an 8N1 frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int cyc);
    int idx;
    idx = cyc / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Called just after the edge that starts the first frame; ends just after the edge that returns to idle.
  task automatic check_stream(input int n_frames);
    for (int i = 0; i < n_frames * FRAME; i++) begin
      chk($sformatf("txd f%0d c%0d", i / FRAME, i % FRAME), uart_txd, exp_bit(exp_q[i / FRAME], i % FRAME));
      tick();
    end
    chk("busy_after_frames", tx_busy, 1'b0);
    chk("txd_idle_after_frames", uart_txd, 1'b1);
  endtask

  initial begin
    int acc;
    int lows;
    int busy_seen;
    logic will_acc;

    rst          = 1'b1;
    uart_tx_en   = 1'b0;
    uart_tx_data = 8'h00;
    tick();
    tick();
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_ready", uart_tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_txd", uart_txd, 1'b1);

    // Single byte 0xA5: line still high right after acceptance, start bit on the next edge.
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'hA5;
    tick();
    uart_tx_en = 1'b0;
    chk("lat_txd_still_high", uart_txd, 1'b1);
    chk("lat_busy", tx_busy, 1'b1);
    tick();
    exp_q[0] = 8'hA5;
    check_stream(1);

    // Boundary data 0x00 then 0xFF on consecutive cycles.
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'h00;
    tick();
    uart_tx_data = 8'hFF;
    chk("bnd_ready", uart_tx_ready, 1'b1);
    tick();
    uart_tx_en = 1'b0;
    exp_q[0] = 8'h00;
    exp_q[1] = 8'hFF;
    check_stream(2);

    // Back-to-back 0x00..0x05 with en held; 0xEE presented while full must be ignored.
    for (int k = 0; k < 6; k++) exp_q[k] = 8'(k);
    acc          = 0;
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'h00;
    for (int c = 0; c <= 240; c++) begin
      will_acc = uart_tx_en && uart_tx_ready;
      tick();
      if (c <= 3) chk($sformatf("b2b_ready_e%0d", c), uart_tx_ready, 1'b1);
      if (c == 4) chk("b2b_ready_drop_after_5th", uart_tx_ready, 1'b0);
      if (c == 40) chk("b2b_ready_still_full", uart_tx_ready, 1'b0);
      if (c == 41) chk("b2b_ready_after_pop", uart_tx_ready, 1'b1);
      if (c == 81) chk("b2b_ready_after_2nd_pop", uart_tx_ready, 1'b1);
      if (will_acc) begin
        acc++;
        uart_tx_data = (acc < 6) ? 8'(acc) : 8'hEE;
      end
      if (c == 42) begin
        chk("b2b_6th_accepted", acc, 6);
        chk("b2b_ready_full_again", uart_tx_ready, 1'b0);
      end
      if (acc == 6 && uart_tx_ready) uart_tx_en = 1'b0;
      if (c >= 1) chk($sformatf("b2b txd c%0d", c), uart_txd, exp_bit(exp_q[(c-1) / FRAME], (c-1) % FRAME));
    end
    tick();
    chk("b2b_accepted_total", acc, 6);
    chk("b2b_busy_end", tx_busy, 1'b0);
    chk("b2b_txd_end", uart_txd, 1'b1);

    // Reset during DATA bit 3 with a second byte queued and a write in the reset cycle.
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'h00;
    tick();
    uart_tx_data = 8'hAA;
    tick();
    uart_tx_en = 1'b0;
    repeat (17) tick();
    chk("pre_rst_data_bit3", uart_txd, 1'b0);
    chk("pre_rst_busy", tx_busy, 1'b1);
    rst          = 1'b1;
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'h55;
    tick();
    rst        = 1'b0;
    uart_tx_en = 1'b0;
    chk("midrst_txd", uart_txd, 1'b1);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_ready", uart_tx_ready, 1'b1);
    lows      = 0;
    busy_seen = 0;
    repeat (60) begin
      tick();
      if (uart_txd !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busy_seen++;
    end
    chk("post_rst_low_cycles", lows, 0);
    chk("post_rst_busy_cycles", busy_seen, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
